// File: rtl/conv_window_sequencer.sv
// Streaming window sequencer: buffers KERNEL_SIZE-1 image lines plus a KxK window from a
// raster-order pixel stream, issues one multiplier request per fully covered window position,
// and forwards the multiplier results to the host with busy/done status.
module conv_window_sequencer #(
    parameter int unsigned BITS        = 9,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMG_WIDTH   = 16,
    parameter int unsigned IMG_HEIGHT  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      kernel_wr_en,
    input  logic [3:0]                                kernel_wr_addr,
    input  logic [BITS-1:0]                           kernel_wr_data,
    input  logic                                      pix_valid,
    input  logic [BITS-1:0]                           pix_in,
    output logic                                      pix_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]   shift_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]   kernel_out,
    output logic                                      mult_out_en,
    input  logic                                      mult_valid,
    input  logic [BITS-1:0]                           mult_pixel,
    output logic                                      out_valid,
    output logic [BITS-1:0]                           out_pixel,
    output logic                                      busy,
    output logic                                      done
);

    localparam int unsigned NumTaps   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned NumLines  = KERNEL_SIZE - 1;
    localparam int unsigned ColW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned NumIssues = (IMG_WIDTH - KERNEL_SIZE + 1) *
                                        (IMG_HEIGHT - KERNEL_SIZE + 1);
    localparam int unsigned OutW      = $clog2(NumIssues + 1);

    localparam logic [ColW-1:0] LastCol     = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] LastRow     = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] FirstWinCol = ColW'(KERNEL_SIZE - 1);
    localparam logic [RowW-1:0] FirstWinRow = RowW'(KERNEL_SIZE - 1);
    localparam logic [3:0]      NumTapsAddr = 4'(NumTaps);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic            issue_q, issue_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_pixel_q, out_pixel_d;

    logic [BITS-1:0] kernel_q [NumTaps];
    logic [BITS-1:0] kernel_d [NumTaps];
    logic [BITS-1:0] win_q    [NumTaps];
    logic [BITS-1:0] win_d    [NumTaps];
    logic [BITS-1:0] lb_q     [NumLines][IMG_WIDTH];
    logic [BITS-1:0] lb_d     [NumLines][IMG_WIDTH];

    logic accept;
    logic in_frame;
    logic take;

    assign accept   = (state_q == StStream) && pix_valid;
    assign in_frame = (state_q == StStream) || (state_q == StDrain);
    // A result is only accepted if a request is pending or being issued this cycle.
    assign take     = mult_valid && in_frame && ((outst_q != '0) || issue_q);

    // FSM next state and raster position counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StStream: begin
                if (accept) begin
                    if (col_q == LastCol) begin
                        col_d = '0;
                        if (row_q == LastRow) begin
                            state_d = StDrain;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + RowW'(1);
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StDrain: begin
                if ((outst_q == '0) && !issue_q) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outstanding request count, issue strobe and registered result path.
    always_comb begin
        outst_d = outst_q;
        if ((state_q == StIdle) && start) begin
            outst_d = '0;
        end else if (issue_q && !take) begin
            outst_d = outst_q + OutW'(1);
        end else if (take && !issue_q) begin
            outst_d = outst_q - OutW'(1);
        end
        issue_d     = accept && (row_q >= FirstWinRow) && (col_q >= FirstWinCol);
        out_valid_d = take;
        out_pixel_d = take ? mult_pixel : out_pixel_q;
    end

    // Kernel writes (IDLE only), window shift and line buffer update on each accepted pixel.
    always_comb begin
        kernel_d = kernel_q;
        win_d    = win_q;
        lb_d     = lb_q;
        if ((state_q == StIdle) && kernel_wr_en && (kernel_wr_addr < NumTapsAddr)) begin
            kernel_d[kernel_wr_addr] = kernel_wr_data;
        end
        if (accept) begin
            for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
                for (int c = 0; c < int'(KERNEL_SIZE) - 1; c++) begin
                    win_d[r*KERNEL_SIZE + c] = win_q[r*KERNEL_SIZE + c + 1];
                end
            end
            // New right column: older lines from the buffers, bottom row from the stream.
            for (int r = 0; r < int'(NumLines); r++) begin
                win_d[r*KERNEL_SIZE + KERNEL_SIZE - 1] = lb_q[r][col_q];
            end
            win_d[NumTaps-1] = pix_in;
            for (int r = 0; r < int'(NumLines) - 1; r++) begin
                lb_d[r][col_q] = lb_q[r+1][col_q];
            end
            lb_d[NumLines-1][col_q] = pix_in;
        end
    end

    // Flatten window and kernel: element (r,c) at [(r*K+c)*BITS +: BITS].
    always_comb begin
        shift_out  = '0;
        kernel_out = '0;
        for (int i = 0; i < int'(NumTaps); i++) begin
            shift_out[i*BITS +: BITS]  = win_q[i];
            kernel_out[i*BITS +: BITS] = kernel_q[i];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            outst_q     <= '0;
            issue_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            outst_q     <= outst_d;
            issue_q     <= issue_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
        end
    end

    // Kernel, window and line buffer storage; all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NumTaps); i++) begin
                kernel_q[i] <= '0;
                win_q[i]    <= '0;
            end
            for (int r = 0; r < int'(NumLines); r++) begin
                for (int c = 0; c < int'(IMG_WIDTH); c++) begin
                    lb_q[r][c] <= '0;
                end
            end
        end else begin
            kernel_q <= kernel_d;
            win_q    <= win_d;
            lb_q     <= lb_d;
        end
    end

    assign pix_ready   = (state_q == StStream);
    assign busy        = in_frame;
    assign done        = (state_q == StDone);
    assign mult_out_en = issue_q;
    assign out_valid   = out_valid_q;
    assign out_pixel   = out_pixel_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 4x4 image with a behavioural multiplier peer.
module tb_conv_window_sequencer;

    localparam int unsigned BITS = 9;
    localparam int unsigned K    = 3;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned WinW = K * K * BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            kernel_wr_en;
    logic [3:0]      kernel_wr_addr;
    logic [BITS-1:0] kernel_wr_data;
    logic            pix_valid;
    logic [BITS-1:0] pix_in;
    logic            pix_ready;
    logic [WinW-1:0] shift_out;
    logic [WinW-1:0] kernel_out;
    logic            mult_out_en;
    logic            mult_valid;
    logic [BITS-1:0] mult_pixel;
    logic            out_valid;
    logic [BITS-1:0] out_pixel;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int done_res = 0;
    logic [BITS-1:0] results [$];
    logic [WinW-1:0] windows [$];

    logic            mv1;
    logic [BITS-1:0] mp1;

    conv_window_sequencer #(
        .BITS        (BITS),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .kernel_wr_en   (kernel_wr_en),
        .kernel_wr_addr (kernel_wr_addr),
        .kernel_wr_data (kernel_wr_data),
        .pix_valid      (pix_valid),
        .pix_in         (pix_in),
        .pix_ready      (pix_ready),
        .shift_out      (shift_out),
        .kernel_out     (kernel_out),
        .mult_out_en    (mult_out_en),
        .mult_valid     (mult_valid),
        .mult_pixel     (mult_pixel),
        .out_valid      (out_valid),
        .out_pixel      (out_pixel),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Saturating signed dot product, as the multiplier computes it.
    function automatic logic [BITS-1:0] mac(input logic [WinW-1:0] w, input logic [WinW-1:0] k);
        int acc;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            acc += int'($signed(w[i*BITS +: BITS])) * int'($signed(k[i*BITS +: BITS]));
        end
        if (acc > 255) acc = 255;
        else if (acc < -256) acc = -256;
        return acc[BITS-1:0];
    endfunction

    // Multiplier peer: two-cycle latency from out_en to output_valid.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv1        <= 1'b0;
            mp1        <= '0;
            mult_valid <= 1'b0;
            mult_pixel <= '0;
        end else begin
            mv1        <= mult_out_en;
            mp1        <= mac(shift_out, kernel_out);
            mult_valid <= mv1;
            mult_pixel <= mp1;
        end
    end

    // Record issues, windows, results and done pulses.
    always @(negedge clk) begin
        if (mult_out_en) begin
            en_cnt <= en_cnt + 1;
            windows.push_back(shift_out);
        end
        if (out_valid) results.push_back(out_pixel);
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_res <= int'(results.size());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WinW-1:0] kpack(input logic [BITS-1:0] v);
        logic [WinW-1:0] p;
        for (int i = 0; i < 9; i++) p[i*BITS +: BITS] = v;
        return p;
    endfunction

    // Window of pixel values i+1 in raster order with top-left corner at (r0,c0).
    function automatic logic [WinW-1:0] win_at(input int r0, input int c0);
        logic [WinW-1:0] p;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*BITS +: BITS] = BITS'((r0 + r) * 4 + (c0 + c) + 1);
        return p;
    endfunction

    function automatic logic [BITS-1:0] get_res(input int idx);
        if (idx < int'(results.size())) return results[idx];
        return 'x;
    endfunction

    function automatic logic [WinW-1:0] get_win(input int idx);
        if (idx < int'(windows.size())) return windows[idx];
        return 'x;
    endfunction

    task automatic kwrite(input int a, input logic [BITS-1:0] v);
        kernel_wr_en   = 1'b1;
        kernel_wr_addr = 4'(a);
        kernel_wr_data = v;
        @(negedge clk);
        kernel_wr_en   = 1'b0;
    endtask

    task automatic kfill(input logic [BITS-1:0] v);
        for (int a = 0; a < 9; a++) kwrite(a, v);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int npix, input bit bubbles, input bit all255, input bit inject);
        int  i;
        bit  phase;
        i     = 0;
        phase = 1'b0;
        while (i < npix) begin
            if (bubbles && phase) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_in    = all255 ? BITS'(255) : BITS'(i + 1);
                if (inject && i == 5) begin
                    start          = 1'b1;
                    kernel_wr_en   = 1'b1;
                    kernel_wr_addr = 4'd0;
                    kernel_wr_data = BITS'(5);
                end
                i++;
            end
            phase = !phase;
            @(negedge clk);
            start        = 1'b0;
            kernel_wr_en = 1'b0;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, " done seen"}, 128'(seen), 128'(1));
        @(negedge clk);
        check({tag, " done single cycle"}, 128'(done), 128'(0));
        check({tag, " busy low after"}, 128'(busy), 128'(0));
    endtask

    task automatic check_frame(input string tag, input int rb, input int eb, input int db,
                               input int e0, input int e1, input int e2, input int e3);
        int exp [4];
        exp = '{e0, e1, e2, e3};
        check({tag, " result count"}, 128'(int'(results.size()) - rb), 128'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("%s result %0d", tag, i), 128'(get_res(rb + i)), 128'(exp[i]));
        check({tag, " out_en count"}, 128'(en_cnt - eb), 128'(4));
        check({tag, " done count"}, 128'(done_cnt - db), 128'(1));
        check({tag, " done after last result"}, 128'(done_res - rb), 128'(4));
    endtask

    initial begin
        int rb, eb, db, wb;
        rst = 1'b1; start = 1'b0; kernel_wr_en = 1'b0; kernel_wr_addr = '0;
        kernel_wr_data = '0; pix_valid = 1'b0; pix_in = '0;
        repeat (2) @(negedge clk);
        check("reset pix_ready", 128'(pix_ready), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset shift_out", 128'(shift_out), 128'(0));
        check("reset kernel_out", 128'(kernel_out), 128'(0));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset mult_out_en", 128'(mult_out_en), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: all-ones kernel, contiguous stream.
        kfill(BITS'(1));
        kwrite(9, BITS'(7));
        check("T1 kernel addr9 ignored", 128'(kernel_out), 128'(kpack(BITS'(1))));
        rb = int'(results.size()); eb = en_cnt; db = done_cnt; wb = int'(windows.size());
        start_frame();
        check("T1 busy in stream", 128'(busy), 128'(1));
        check("T1 pix_ready in stream", 128'(pix_ready), 128'(1));
        feed(16, 1'b0, 1'b0, 1'b0);
        wait_done("T1");
        check_frame("T1", rb, eb, db, 54, 63, 90, 99);
        check("T1 first window", 128'(get_win(wb)), 128'(win_at(0, 0)));
        check("T1 last window", 128'(get_win(wb + 3)), 128'(win_at(1, 1)));

        // Scenario 2: centre tap only.
        for (int a = 0; a < 9; a++) kwrite(a, (a == 4) ? BITS'(1) : BITS'(0));
        rb = int'(results.size()); eb = en_cnt; db = done_cnt;
        start_frame();
        feed(16, 1'b0, 1'b0, 1'b0);
        wait_done("T2");
        check_frame("T2", rb, eb, db, 6, 7, 10, 11);

        // Scenario 3: bubbles every other cycle.
        kfill(BITS'(1));
        rb = int'(results.size()); eb = en_cnt; db = done_cnt;
        start_frame();
        feed(16, 1'b1, 1'b0, 1'b0);
        wait_done("T3");
        check_frame("T3", rb, eb, db, 54, 63, 90, 99);

        // Scenario 4: start and kernel write while streaming are ignored.
        rb = int'(results.size()); eb = en_cnt; db = done_cnt;
        start_frame();
        feed(16, 1'b0, 1'b0, 1'b1);
        check("T4 kernel frozen", 128'(kernel_out), 128'(kpack(BITS'(1))));
        wait_done("T4");
        check_frame("T4", rb, eb, db, 54, 63, 90, 99);

        // Scenario 5: reset after the 10th pixel.
        db = done_cnt;
        start_frame();
        feed(10, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("T5 rst busy", 128'(busy), 128'(0));
        check("T5 rst pix_ready", 128'(pix_ready), 128'(0));
        check("T5 rst shift_out", 128'(shift_out), 128'(0));
        check("T5 rst kernel_out", 128'(kernel_out), 128'(0));
        check("T5 rst out_valid", 128'(out_valid), 128'(0));
        check("T5 rst mult_out_en", 128'(mult_out_en), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("T5 no done after rst", 128'(done_cnt - db), 128'(0));
        check("T5 idle after rst", 128'(busy), 128'(0));
        kfill(BITS'(1));
        rb = int'(results.size()); eb = en_cnt; db = done_cnt;
        start_frame();
        feed(16, 1'b0, 1'b0, 1'b0);
        wait_done("T5");
        check_frame("T5", rb, eb, db, 54, 63, 90, 99);

        // Scenario 6: saturation with all-255 kernel and pixels.
        kfill(BITS'(255));
        rb = int'(results.size()); eb = en_cnt; db = done_cnt;
        start_frame();
        feed(16, 1'b0, 1'b1, 1'b0);
        wait_done("T6");
        check_frame("T6", rb, eb, db, 255, 255, 255, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Streaming sequencer that feeds the convolution `multiplier` datapath from a raster-order pixel stream.
- Holds the kernel coefficients and buffers two image lines to form the KERNEL_SIZE x KERNEL_SIZE window.
- Issues one `out_en` per valid (non-padded) window position and collects the multiplier's results.
- Sits between the pixel source (Wishbone/LA-fed) and the multiplier, and reports busy/done to the host.

Parameters:
- BITS, 9, pixel/coefficient width (signed two's complement).
- KERNEL_SIZE, 3, window edge; the design is only required to support 3.
- IMG_WIDTH, 16, pixels per line (>= KERNEL_SIZE).
- IMG_HEIGHT, 16, lines per frame (>= KERNEL_SIZE).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin frame; honoured only in IDLE.
- kernel_wr_en  in  1  coefficient write strobe; honoured only in IDLE.
- kernel_wr_addr  in  4  coefficient index a = r*KERNEL_SIZE+c; writes with a >= 9 are ignored.
- kernel_wr_data  in  BITS  coefficient value.
- pix_valid  in  1  source pixel valid.
- pix_in  in  BITS  source pixel.
- pix_ready  out  1  sequencer accepts pixel; a pixel transfers when pix_valid & pix_ready.
- shift_out  out  K*K*BITS  window to multiplier `shift_in`.
- kernel_out  out  K*K*BITS  coefficients to multiplier `kernel_in`.
- mult_out_en  out  1  to multiplier `out_en`.
- mult_valid  in  1  from multiplier `output_valid`.
- mult_pixel  in  BITS  from multiplier `pixel_out`.
- out_valid  out  1  result pixel valid, single-cycle pulse.
- out_pixel  out  BITS  result pixel.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, kernel registers 0, window and line buffers 0.
- Packing (`shift_out` and `kernel_out`): element (r,c) occupies bits [(r*K+c)*BITS +: BITS]. r=0 is the oldest (top) row; c=0 is the oldest (left) column.
- FSM:
  - IDLE: on `start`, go to STREAM. Clear col/row/outstanding/output counters.
  - STREAM: `pix_ready`=1. Each accepted pixel shifts into the window and line buffers. col increments; at IMG_WIDTH-1 it wraps to 0 and row increments. On acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to DRAIN; `pix_ready` is 0 from the next cycle.
  - DRAIN: wait until outstanding==0 and no `mult_out_en` is in flight, then go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- Window issue: when the accepted pixel has row>=2 and col>=2, `mult_out_en` is driven high on the next cycle for exactly one cycle. `shift_out` holds the updated window and stays stable until the next accepted pixel. There is no padding: a frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) issues. Line wrap never produces a window that straddles two lines.
- Outstanding counter:
  - +1 on `mult_out_en`, -1 on `mult_valid`; unchanged when both occur in the same cycle.
  - `mult_valid` while outstanding==0 and no `mult_out_en` is issued in that cycle: result is dropped and the counter is not decremented.
- Output path: `out_valid`/`out_pixel` register `mult_valid`/`mult_pixel` (1-cycle latency), only in STREAM/DRAIN. `mult_valid` in IDLE/DONE is ignored. There is no output backpressure.
- Kernel: `kernel_out` is driven continuously from the kernel registers. Writes in non-IDLE states are ignored, so coefficients are frozen for the whole frame.
- Bubbles: `pix_valid` low stalls all counters; the window is unaffected.
- `start` while busy is ignored.
- `rst` mid-frame returns immediately to IDLE with all state cleared, including the kernel registers. No `done` pulse is generated.

Test Plan:
1. IMG 4x4; kernel all 1 (addr 0..8 = 1); pixels 1..16 with `pix_valid` held high -> exactly four `mult_out_en` pulses; `out_pixel` sequence 54, 63, 90, 99; then a single `done` pulse; `busy` low afterwards.
2. IMG 4x4; kernel center only (addr 4 = 1, others 0); pixels 1..16 -> outputs 6, 7, 10, 11; checks packing order and line wrap (no window issued at col 0/1).
3. Same as 1 with `pix_valid` deasserted every other cycle -> same four results in the same order; `mult_out_en` count still 4.
4. Issue `start` and `kernel_wr_en` (addr 0 = 5) during STREAM -> no FSM restart; `kernel_out` unchanged; results identical to scenario 1.
5. Assert `rst` after the 10th pixel of scenario 1 -> all outputs 0 the same cycle; no `done`; a fresh frame after re-writing the kernel gives the scenario 1 results.
6. Kernel all 255, pixels all 255 -> every `out_pixel` = 255 (saturated by the multiplier); `done` is asserted only after the 4th result.
